// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scancode parser with held-key tracking and FWFT event FIFO
module ps2_key_decoder #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         scan_data,
  input  logic               scan_valid,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_break,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         held_code,
  output logic               held_ext,
  output logic               held_valid,
  output logic [7:0]         press_count,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state, state_nx;

  logic is_make, is_break, ev_ext;
  logic byte_e0, byte_f0, byte_null;

  assign byte_e0   = (scan_data == 8'hE0);
  assign byte_f0   = (scan_data == 8'hF0);
  assign byte_null = (scan_data == 8'h00) || (scan_data == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    is_make  = 1'b0;
    is_break = 1'b0;
    ev_ext   = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (byte_e0)        state_nx = GOT_E0;
          else if (byte_f0)   state_nx = GOT_F0;
          else if (!byte_null) is_make = 1'b1;
        end
        GOT_E0: begin
          if (byte_f0)        state_nx = GOT_E0F0;
          else if (byte_e0)   state_nx = GOT_E0;
          else begin
            state_nx = IDLE;
            is_make  = !byte_null;
            ev_ext   = 1'b1;
          end
        end
        GOT_F0: begin
          state_nx = IDLE;
          is_break = !(byte_e0 || byte_f0 || byte_null);
        end
        GOT_E0F0: begin
          state_nx = IDLE;
          is_break = !(byte_e0 || byte_f0 || byte_null);
          ev_ext   = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // A make matching the held key is typematic repeat and is swallowed entirely.
  logic held_match, new_make, push;
  assign held_match = held_valid && (held_ext == ev_ext) && (held_code == scan_data);
  assign new_make   = is_make && !held_match;
  assign push       = new_make || is_break;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_code   <= '0;
      held_ext    <= 1'b0;
      held_valid  <= 1'b0;
      press_count <= '0;
    end else if (new_make) begin
      held_code   <= scan_data;
      held_ext    <= ev_ext;
      held_valid  <= 1'b1;
      press_count <= press_count + 8'd1;
    end else if (is_break && held_match) begin
      held_valid  <= 1'b0;
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, pop, push_ok;
  logic [9:0]         head;

  assign full      = (fifo_level == FULL_LEVEL);
  assign evt_valid = (fifo_level != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {ev_ext, is_break, scan_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push_ok) fifo_level <= fifo_level - 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Fields are forced to zero when empty so the head never exposes stale storage.
  assign head      = evt_valid ? mem[rd_ptr] : 10'd0;
  assign evt_ext   = head[9];
  assign evt_break = head[8];
  assign evt_code  = head[7:0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] held_code;
  logic       held_ext, held_valid;
  logic [7:0] press_count;
  logic [3:0] fifo_level;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q [$];

  ps2_key_decoder #(.FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .held_code(held_code), .held_ext(held_ext), .held_valid(held_valid),
    .press_count(press_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    scan_data = b; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0; scan_data = 8'h00;
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && fifo_level != 0; i++) @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted head event is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_evt", 32'({evt_ext, evt_break, evt_code}), 32'h3FF);
      else chk("evt", 32'({evt_ext, evt_break, evt_code}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_evt_fields", 32'({evt_ext, evt_break, evt_code}), 32'd0);
    chk("rst_held", 32'({held_valid, held_ext, held_code}), 32'd0);
    chk("rst_press", 32'(press_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    evt_ready = 1'b1;

    // make then break of 1C
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    chk("latency_valid", 32'(evt_valid), 32'd1);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send(8'hF0); send(8'h1C);
    wait_drain();
    chk("t32_press", 32'(press_count), 32'd1);
    chk("t32_held_valid", 32'(held_valid), 32'd0);

    // typematic repeat plus ignored filler bytes
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C); send(8'h1C); send(8'hFF); send(8'h1C); send(8'h00);
    wait_drain();
    chk("t33_press", 32'(press_count), 32'd2);
    chk("t33_held", 32'({held_valid, held_ext, held_code}), 32'h21C);

    // extended make/break, then F0 E0 protocol error returns to IDLE
    expect_evt(1'b1, 1'b0, 8'h75);
    send(8'hE0); send(8'h75);
    chk("t34_held_ext", 32'({held_valid, held_ext, held_code}), 32'h375);
    expect_evt(1'b1, 1'b1, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t34_held_clear", 32'(held_valid), 32'd0);
    send(8'hF0); send(8'hE0);
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    wait_drain();
    chk("t34_press", 32'(press_count), 32'd4);

    // overflow: nine makes into an 8-deep FIFO with the consumer stalled
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_evt(1'b0, 1'b0, 8'(8'h10 + i));
      send(8'(8'h10 + i));
      if (i == 0) chk("t35_head_first", 32'(evt_code), 32'h10);
    end
    @(negedge clk);
    chk("t35_level_full", 32'(fifo_level), 32'd8);
    chk("t35_overflow", 32'(overflow), 32'd1);
    chk("t35_head_stable", 32'({evt_ext, evt_break, evt_code}), 32'h010);
    chk("t35_press", 32'(press_count), 32'd13);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h19);
    scan_data = 8'h19; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0; scan_data = 8'h00;
    chk("t35_level_pushpop", 32'(fifo_level), 32'd8);
    wait_drain();
    chk("t35_press_final", 32'(press_count), 32'd14);
    chk("t35_overflow_sticky", 32'(overflow), 32'd1);

    // reset mid-prefix discards the E0
    send(8'hE0);
    #2 reset = 1'b0;
    #1;
    chk("t36_rst_overflow", 32'(overflow), 32'd0);
    chk("t36_rst_press", 32'(press_count), 32'd0);
    chk("t36_rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    wait_drain();
    chk("t36_press", 32'(press_count), 32'd1);
    chk("t36_overflow", 32'(overflow), 32'd0);
    chk("t36_held", 32'({held_valid, held_ext, held_code}), 32'h21C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
